// File: rtl/v_pkg.sv
// -----------------------------------------------------------------------------
// v_pkg
// Shared vector-unit definitions: major opcodes, the vector-config funct3
// encoding, instruction-queue state type and classification helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package v_pkg;

  // Major opcodes that carry vector instructions (OP-V, LOAD-FP, STORE-FP)
  localparam logic [6:0] OPC_RTYPE = 7'h57;
  localparam logic [6:0] OPC_LTYPE = 7'h07;
  localparam logic [6:0] OPC_STYPE = 7'h27;

  // funct3 value under OPC_RTYPE that selects vsetvli/vsetivli/vsetvl
  localparam logic [2:0] OP_SET    = 3'b111;

  localparam int VIQ_DEPTH_DEFAULT = 4;

  typedef enum logic {
    VIQ_RUN      = 1'b0,
    VIQ_WAIT_CFG = 1'b1
  } viq_state_t;

  // True when the opcode belongs to the vector extension
  function automatic logic is_vector_opc(input logic [6:0] opc);
    logic hit;
    hit = 1'b0;
    case (opc)
      OPC_RTYPE, OPC_LTYPE, OPC_STYPE: hit = 1'b1;
      default:                         hit = 1'b0;
    endcase
    return hit;
  endfunction

  // True when the instruction updates vtype/vl
  function automatic logic is_vcfg(input logic [6:0] opc, input logic [2:0] funct3);
    return (opc == OPC_RTYPE) && (funct3 == OP_SET);
  endfunction

endpackage

// File: rtl/v_sync_fifo.sv
// -----------------------------------------------------------------------------
// v_sync_fifo
// First-word-fall-through synchronous FIFO with flush.
// Ports:
//   clk    - clock
//   nrst   - synchronous active-low reset
//   flush  - drop all entries (wins over push/pop)
//   push   - write wdata at tail (ignored when full)
//   pop    - advance head (ignored when empty)
//   wdata  - write data
//   rdata  - head data, straight from storage; zero when empty
//   full   - count == DEPTH
//   empty  - count == 0
//   count  - current occupancy
// -----------------------------------------------------------------------------
module v_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  // A full FIFO refuses pushes even when a pop frees a slot this cycle
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; DEPTH is a power of two so the
  // pointers wrap on natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because rdata is masked when empty
  always_ff @(posedge clk) begin
    if (nrst && !flush && push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/v_instr_queue.sv
// -----------------------------------------------------------------------------
// v_instr_queue
// Vector instruction queue in front of the vector decoder. Filters out
// non-vector opcodes, buffers vector instructions with their scalar operands
// in a FWFT FIFO and holds issue after a vector-config instruction until the
// config update is acknowledged.
// Ports:
//   clk, nrst                  - clock, synchronous active-low reset
//   in_valid/in_ready          - handshake from the scalar core
//   instr_in, rs1_in, rs2_in   - incoming instruction and scalar operands
//   out_valid/out_ready        - handshake to the decoder
//   instr_out, rs1_out, rs2_out- head entry (zero when empty)
//   cfg_ack                    - pulse: vtype/vl update done
//   flush                      - discard all entries, cancel config wait
//   count                      - occupancy
//   drop_pulse                 - registered: a non-vector instr was discarded
// -----------------------------------------------------------------------------
module v_instr_queue
  import v_pkg::*;
#(
  parameter int DEPTH = VIQ_DEPTH_DEFAULT,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         instr_in,
  input  logic [XLEN-1:0]         rs1_in,
  input  logic [XLEN-1:0]         rs2_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         instr_out,
  output logic [XLEN-1:0]         rs1_out,
  output logic [XLEN-1:0]         rs2_out,
  input  logic                    cfg_ack,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    drop_pulse
);

  localparam int W = 3 * XLEN;

  viq_state_t     state_q, state_d, fsm_next_s;
  logic           drop_q, drop_d;
  logic           fifo_full_s, fifo_empty_s;
  logic [W-1:0]   head_s;
  logic           is_vec_s, accept_s, push_s, pop_s, head_is_cfg_s;

  assign in_ready  = !fifo_full_s;
  // Issue is blocked while a config update is outstanding
  assign out_valid = !fifo_empty_s && (state_q == VIQ_RUN);
  assign {instr_out, rs1_out, rs2_out} = head_s;
  assign drop_pulse = drop_q;

  assign is_vec_s      = is_vector_opc(instr_in[6:0]);
  // Anything presented during flush is thrown away without a drop report
  assign accept_s      = in_valid && in_ready && !flush;
  assign push_s        = accept_s && is_vec_s;
  assign pop_s         = out_valid && out_ready && !flush;
  assign head_is_cfg_s = is_vcfg(instr_out[6:0], instr_out[14:12]);
  assign drop_d        = accept_s && !is_vec_s;

  v_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .flush (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({instr_in, rs1_in, rs2_in}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count)
  );

  // Config-wait next state; a vconfig pop beats a same-cycle cfg_ack
  always_comb begin
    fsm_next_s = state_q;
    case (state_q)
      VIQ_RUN: begin
        if (pop_s && head_is_cfg_s) begin
          fsm_next_s = VIQ_WAIT_CFG;
        end else begin
          fsm_next_s = VIQ_RUN;
        end
      end
      VIQ_WAIT_CFG: begin
        if (cfg_ack) begin
          fsm_next_s = VIQ_RUN;
        end else begin
          fsm_next_s = VIQ_WAIT_CFG;
        end
      end
      default: fsm_next_s = VIQ_RUN;
    endcase
    if (flush) begin
      state_d = VIQ_RUN;
    end else begin
      state_d = fsm_next_s;
    end
  end

  // FSM state and drop-report registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= VIQ_RUN;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_v_instr_queue.sv
module tb_v_instr_queue;

  localparam logic [31:0] I_A = 32'h0220_8057;  // vadd.vv
  localparam logic [31:0] I_B = 32'h0205_E007;  // vle32.v
  localparam logic [31:0] I_C = 32'h0205_E027;  // vse32.v
  localparam logic [31:0] I_D = 32'h0231_0057;  // vadd.vv (other regs)
  localparam logic [31:0] I_S = 32'h00B5_0533;  // scalar add
  localparam logic [31:0] I_V = 32'h0085_F557;  // vsetvli

  logic        clk = 1'b0;
  logic        nrst, in_valid, in_ready, out_valid, out_ready;
  logic        cfg_ack, flush, drop_pulse;
  logic [31:0] instr_in, rs1_in, rs2_in, instr_out, rs1_out, rs2_out;
  logic [2:0]  count;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  v_instr_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_in   (instr_in),
    .rs1_in     (rs1_in),
    .rs2_in     (rs2_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .rs1_out    (rs1_out),
    .rs2_out    (rs2_out),
    .cfg_ack    (cfg_ack),
    .flush      (flush),
    .count      (count),
    .drop_pulse (drop_pulse)
  );

  typedef struct {
    logic        rn, iv;
    logic [31:0] ins, r1, r2;
    logic        ordy, ack, fl;
    logic        e_rdy, e_ov;
    logic [2:0]  e_cnt;
    logic        e_drop;
    logic [31:0] e_ins, e_r1, e_r2;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic rn, logic iv, logic [31:0] ins, logic [31:0] r1,
                              logic [31:0] r2, logic ordy, logic e_rdy, logic e_ov,
                              logic [2:0] e_cnt, logic e_drop, logic [31:0] e_ins,
                              logic [31:0] e_r1, logic [31:0] e_r2);
    vec_t v;
    v.rn = rn; v.iv = iv; v.ins = ins; v.r1 = r1; v.r2 = r2;
    v.ordy = ordy; v.ack = 1'b0; v.fl = 1'b0;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_cnt = e_cnt; v.e_drop = e_drop;
    v.e_ins = e_ins; v.e_r1 = e_r1; v.e_r2 = e_r2;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic rn, input logic iv, input logic [31:0] ins,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic ordy, input logic ack, input logic fl);
    nrst = rn; in_valid = iv; instr_in = ins; rs1_in = r1; rs2_in = r2;
    out_ready = ordy; cfg_ack = ack; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic rdy, input logic ov,
                           input logic [2:0] cnt, input logic [31:0] ins);
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".count"},     {29'd0, count},     {29'd0, cnt});
    check({tag, ".instr_out"}, instr_out, ins);
  endtask

  logic [31:0] model_q[$];

  initial begin
    nrst = 1'b0; in_valid = 1'b0; instr_in = 32'd0; rs1_in = 32'd0; rs2_in = 32'd0;
    out_ready = 1'b0; cfg_ack = 1'b0; flush = 1'b0;

    //        rn    iv    ins  r1     r2     ordy  rdy   ov    cnt   drop  e_ins e_r1   e_r2
    vt[0]  = mk(1'b0, 1'b0, I_A, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    vt[1]  = mk(1'b1, 1'b1, I_A, 32'h11, 32'h21, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, I_A, 32'h11, 32'h21);
    vt[2]  = mk(1'b1, 1'b1, I_B, 32'h12, 32'h22, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, I_A, 32'h11, 32'h21);
    vt[3]  = mk(1'b1, 1'b1, I_C, 32'h13, 32'h23, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, I_A, 32'h11, 32'h21);
    vt[4]  = mk(1'b1, 1'b1, I_D, 32'h14, 32'h24, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, I_A, 32'h11, 32'h21);
    // Scalar presented while full: refused, no drop report
    vt[5]  = mk(1'b1, 1'b1, I_S, 32'h99, 32'h99, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, I_A, 32'h11, 32'h21);
    vt[6]  = mk(1'b1, 1'b0, I_S, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, I_B, 32'h12, 32'h22);
    vt[7]  = mk(1'b1, 1'b0, I_S, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, I_C, 32'h13, 32'h23);
    vt[8]  = mk(1'b1, 1'b0, I_S, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, I_D, 32'h14, 32'h24);
    vt[9]  = mk(1'b1, 1'b0, I_S, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    // Filter: scalar add dropped, pulse is registered one cycle, then clears
    vt[10] = mk(1'b1, 1'b1, I_S, 32'h5, 32'h6, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    vt[11] = mk(1'b1, 1'b0, I_S, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    // Refill across pointer wrap, then push+pop while full (no push-through)
    vt[12] = mk(1'b1, 1'b1, I_A, 32'h31, 32'h41, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, I_A, 32'h31, 32'h41);
    vt[13] = mk(1'b1, 1'b1, I_B, 32'h32, 32'h42, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, I_A, 32'h31, 32'h41);
    vt[14] = mk(1'b1, 1'b1, I_C, 32'h33, 32'h43, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, I_A, 32'h31, 32'h41);
    vt[15] = mk(1'b1, 1'b1, I_D, 32'h34, 32'h44, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, I_A, 32'h31, 32'h41);
    vt[16] = mk(1'b1, 1'b1, I_A, 32'h77, 32'h77, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, I_B, 32'h32, 32'h42);
    vt[17] = mk(1'b1, 1'b0, I_A, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, I_C, 32'h33, 32'h43);
    vt[18] = mk(1'b1, 1'b0, I_A, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, I_D, 32'h34, 32'h44);
    vt[19] = mk(1'b1, 1'b0, I_A, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      step(vt[i].rn, vt[i].iv, vt[i].ins, vt[i].r1, vt[i].r2, vt[i].ordy, vt[i].ack, vt[i].fl);
      expect_st($sformatf("v%0d", i), vt[i].e_rdy, vt[i].e_ov, vt[i].e_cnt, vt[i].e_ins);
      check($sformatf("v%0d.drop", i), {31'd0, drop_pulse}, {31'd0, vt[i].e_drop});
      check($sformatf("v%0d.rs1", i), rs1_out, vt[i].e_r1);
      check($sformatf("v%0d.rs2", i), rs2_out, vt[i].e_r2);
    end

    // Vconfig stall: vsetvli pops, vle32 waits for cfg_ack
    step(1'b1, 1'b1, I_V, 32'h50, 32'h60, 1'b1, 1'b0, 1'b0);
    expect_st("cfg.push", 1'b1, 1'b1, 3'd1, I_V);
    step(1'b1, 1'b1, I_B, 32'h51, 32'h61, 1'b1, 1'b0, 1'b0);
    expect_st("cfg.pop", 1'b1, 1'b0, 3'd1, I_B);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      expect_st($sformatf("cfg.wait%0d", k), 1'b1, 1'b0, 3'd1, I_B);
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_st("cfg.ack", 1'b1, 1'b1, 3'd1, I_B);
    check("cfg.rs1", rs1_out, 32'h51);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);  // ack in RUN ignored
    expect_st("cfg.drain", 1'b1, 1'b0, 3'd0, 32'h0);

    // cfg_ack coinciding with a vconfig pop is lost
    step(1'b1, 1'b1, I_V, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, I_A, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0);
    expect_st("race.pop", 1'b1, 1'b0, 3'd1, I_A);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_st("race.hold", 1'b1, 1'b0, 3'd1, I_A);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_st("race.ack", 1'b1, 1'b1, 3'd1, I_A);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_st("race.drain", 1'b1, 1'b0, 3'd0, 32'h0);

    // Flush while in WAIT_CFG with count=3, instruction presented alongside
    step(1'b1, 1'b1, I_V, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, I_A, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, I_B, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0);   // pops vsetvli
    step(1'b1, 1'b1, I_C, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    expect_st("fl.pre", 1'b1, 1'b0, 3'd3, I_A);
    step(1'b1, 1'b1, I_D, 32'h9, 32'hA, 1'b1, 1'b0, 1'b1);
    expect_st("fl.post", 1'b1, 1'b0, 3'd0, 32'h0);
    step(1'b1, 1'b1, I_C, 32'hB, 32'hC, 1'b0, 1'b0, 1'b0);
    expect_st("fl.run", 1'b1, 1'b1, 3'd1, I_C);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_st("fl.drain", 1'b1, 1'b0, 3'd0, 32'h0);

    // Simultaneous push/pop at count=2 for 10 cycles, checked against a queue model
    model_q.delete();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] w;
      w = 32'h0000_0057 | (32'(k + 1) << 20);
      step(1'b1, 1'b1, w, 32'(k), ~32'(k), (k >= 2), 1'b0, 1'b0);
      if (k >= 2) void'(model_q.pop_front());
      model_q.push_back(w);
      expect_st($sformatf("pp%0d", k), 1'b1, 1'b1, (k >= 1) ? 3'd2 : 3'd1, model_q[0]);
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_st("pp.drain", 1'b1, 1'b0, 3'd0, 32'h0);

    // Reset mid-stream with count=3
    step(1'b1, 1'b1, I_A, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, I_S, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, I_B, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, I_C, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_st("rst.pre", 1'b1, 1'b1, 3'd3, I_A);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_st("rst.hit", 1'b1, 1'b0, 3'd0, 32'h0);
    check("rst.rs1", rs1_out, 32'h0);
    check("rst.drop", {31'd0, drop_pulse}, 32'd0);
    step(1'b1, 1'b1, I_D, 32'hAB, 32'hCD, 1'b0, 1'b0, 1'b0);
    expect_st("rst.push", 1'b1, 1'b1, 3'd1, I_D);
    check("rst.rs2", rs2_out, 32'hCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
